// File: rtl/sync_debounce.sv
// Per-bit debounce filter with registered rise/fall pulses and sticky event flags.
// The input bus must already be synchronous to clock.
module sync_debounce #(
    parameter int unsigned         WIDTH_MSB       = 0,
    parameter int unsigned         DEBOUNCE_CYCLES = 4,
    parameter logic [WIDTH_MSB:0]  RESET_VALUE     = '0
) (
    input  logic                 clock,
    input  logic                 reset_l,
    input  logic [WIDTH_MSB:0]   data_in,
    output logic [WIDTH_MSB:0]   data_out,
    output logic [WIDTH_MSB:0]   rise,
    output logic [WIDTH_MSB:0]   fall,
    output logic                 any_change,
    output logic [WIDTH_MSB:0]   event_sticky,
    input  logic [WIDTH_MSB:0]   event_clear
);

    localparam int unsigned W     = WIDTH_MSB + 1;
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0]  cnt      [W];
    logic [CNT_W-1:0]  cnt_next [W];
    logic [WIDTH_MSB:0] data_next;
    logic [WIDTH_MSB:0] rise_next;
    logic [WIDTH_MSB:0] fall_next;
    logic [WIDTH_MSB:0] sticky_next;

    // Count consecutive differing samples; accept the new level on the last one.
    always_comb begin
        data_next = data_out;
        rise_next = '0;
        fall_next = '0;
        for (int i = 0; i < W; i++) begin
            cnt_next[i] = '0;
            if (data_in[i] != data_out[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    data_next[i] = data_in[i];
                    rise_next[i] = data_in[i];
                    fall_next[i] = ~data_in[i];
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
        // A new event wins over a simultaneous clear so nothing is lost.
        sticky_next = (event_sticky & ~event_clear) | rise_next | fall_next;
    end

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            data_out     <= RESET_VALUE;
            rise         <= '0;
            fall         <= '0;
            any_change   <= 1'b0;
            event_sticky <= '0;
            for (int i = 0; i < W; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            data_out     <= data_next;
            rise         <= rise_next;
            fall         <= fall_next;
            any_change   <= |(rise_next | fall_next);
            event_sticky <= sticky_next;
            for (int i = 0; i < W; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: directed table, multi-cycle corner sequences and
// randomized traffic against a sample-window reference model.
module tb_sync_debounce;

    localparam int N_A = 4;
    localparam int N_B = 1;

    typedef struct packed {
        logic [3:0] din;
        logic [3:0] clr;
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       any;
        logic [3:0] sticky;
    } vec_t;

    // Reference: a level is accepted once the last N samples since reset all differ from it.
    typedef struct packed {
        logic [3:0]      out;
        logic [3:0]      sticky;
        logic [3:0][3:0] h;
        int              n;
    } model_t;

    logic       clock = 1'b0;
    logic       reset_l;
    logic [3:0] din_a, clr_a, out_a, rise_a, fall_a, st_a;
    logic [3:0] din_b, clr_b, out_b, rise_b, fall_b, st_b;
    logic       any_a, any_b;

    int passed = 0;
    int total  = 0;

    vec_t   tbl [11];
    model_t ma, mb;

    always #5 clock = ~clock;

    sync_debounce #(.WIDTH_MSB(3), .DEBOUNCE_CYCLES(N_A), .RESET_VALUE(4'b0000)) dut_a (
        .clock(clock), .reset_l(reset_l), .data_in(din_a), .data_out(out_a),
        .rise(rise_a), .fall(fall_a), .any_change(any_a),
        .event_sticky(st_a), .event_clear(clr_a)
    );

    sync_debounce #(.WIDTH_MSB(3), .DEBOUNCE_CYCLES(N_B), .RESET_VALUE(4'b0000)) dut_b (
        .clock(clock), .reset_l(reset_l), .data_in(din_b), .data_out(out_b),
        .rise(rise_b), .fall(fall_b), .any_change(any_b),
        .event_sticky(st_b), .event_clear(clr_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic chk_a(input string tag, input logic [3:0] o, input logic [3:0] r,
                         input logic [3:0] f, input logic a, input logic [3:0] s);
        check({tag, ".a.out"},    32'(out_a),  32'(o));
        check({tag, ".a.rise"},   32'(rise_a), 32'(r));
        check({tag, ".a.fall"},   32'(fall_a), 32'(f));
        check({tag, ".a.any"},    32'(any_a),  32'(a));
        check({tag, ".a.sticky"}, 32'(st_a),   32'(s));
    endtask

    task automatic chk_b(input string tag, input logic [3:0] o, input logic [3:0] r,
                         input logic [3:0] f, input logic a, input logic [3:0] s);
        check({tag, ".b.out"},    32'(out_b),  32'(o));
        check({tag, ".b.rise"},   32'(rise_b), 32'(r));
        check({tag, ".b.fall"},   32'(fall_b), 32'(f));
        check({tag, ".b.any"},    32'(any_b),  32'(a));
        check({tag, ".b.sticky"}, 32'(st_b),   32'(s));
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset(output model_t m);
        m = '0;
    endtask

    task automatic model_step(input model_t mi, input logic [3:0] din, input logic [3:0] clr,
                              input int depth, output model_t mo,
                              output logic [3:0] r, output logic [3:0] f);
        logic acc;
        mo = mi;
        for (int k = 3; k > 0; k--) mo.h[k] = mo.h[k-1];
        mo.h[0] = din;
        if (mo.n < 4) mo.n = mo.n + 1;
        r = '0;
        f = '0;
        for (int i = 0; i < 4; i++) begin
            acc = (mo.n >= depth);
            for (int k = 0; k < depth; k++) begin
                if (mo.h[k][i] == mi.out[i]) acc = 1'b0;
            end
            if (acc) begin
                mo.out[i] = din[i];
                r[i] = din[i];
                f[i] = ~din[i];
            end
        end
        mo.sticky = (mi.sticky & ~clr) | r | f;
    endtask

    initial begin
        int         nfall;
        logic [3:0] er, ef;
        logic [3:0] er_b, ef_b;

        // din, clr, out, rise, fall, any, sticky
        tbl[0]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000};
        tbl[1]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000};
        tbl[2]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000};
        tbl[3]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000};
        tbl[4]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000};
        tbl[5]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000};
        tbl[6]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000};
        tbl[7]  = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0001};
        tbl[8]  = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0001};
        tbl[9]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0000};
        tbl[10] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0000};

        // Reset held with the input already high, then released.
        reset_l = 1'b0;
        din_a = 4'b1111; clr_a = '0;
        din_b = 4'b0000; clr_b = '0;
        repeat (3) step();
        chk_a("in_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        chk_b("in_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        reset_l = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            step();
            chk_a($sformatf("post_rst_e%0d", e), 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        end
        step();
        chk_a("post_rst_e4", 4'b1111, 4'b1111, 4'b0000, 1'b1, 4'b1111);
        step();
        chk_a("post_rst_e5", 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b1111);

        // Falling edge held 10 cycles: exactly one fall pulse, sticky kept.
        din_a = 4'b0000;
        nfall = 0;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (fall_a[1]) nfall++;
            if (e == 4) chk_a("fall_e4", 4'b0000, 4'b0000, 4'b1111, 1'b1, 4'b1111);
        end
        check("fall1_pulse_count", 32'(nfall), 32'd1);
        check("fall_sticky_held", 32'(st_a), 32'(4'b1111));
        clr_a = 4'b0010;
        step();
        check("clear_bit1", 32'(st_a), 32'(4'b1101));
        clr_a = 4'b1111;
        step();
        check("clear_all", 32'(st_a), 32'(4'b0000));
        clr_a = 4'b0000;

        // Glitch rejection and accepted rise, table-driven.
        foreach (tbl[k]) begin
            din_a = tbl[k].din;
            clr_a = tbl[k].clr;
            step();
            chk_a($sformatf("tbl%0d", k), tbl[k].out, tbl[k].rise, tbl[k].fall, tbl[k].any, tbl[k].sticky);
        end
        clr_a = 4'b0000;

        // Clear held on bit 2 while its transition completes: set wins for one cycle.
        clr_a = 4'b0100;
        din_a = 4'b0101;
        for (int e = 1; e <= 3; e++) begin
            step();
            chk_a($sformatf("collide_e%0d", e), 4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        end
        step();
        chk_a("collide_e4", 4'b0101, 4'b0100, 4'b0000, 1'b1, 4'b0100);
        step();
        chk_a("collide_e5", 4'b0101, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        clr_a = 4'b0000;

        // Asynchronous reset after 3 of 4 differing edges discards the count.
        din_a = 4'b0111;
        repeat (3) step();
        chk_a("pre_midrst", 4'b0101, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        #3 reset_l = 1'b0;
        #1 chk_a("midrst", 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        #2 reset_l = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            step();
            chk_a($sformatf("after_midrst_e%0d", e), 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        end
        step();
        chk_a("after_midrst_e4", 4'b0111, 4'b0111, 4'b0000, 1'b1, 4'b0111);

        // Single-cycle debounce: plain registered edge detect.
        din_b = 4'b0101;
        step();
        chk_b("n1_first", 4'b0101, 4'b0101, 4'b0000, 1'b1, 4'b0101);
        step();
        chk_b("n1_hold", 4'b0101, 4'b0000, 4'b0000, 1'b0, 4'b0101);
        din_b = 4'b1010;
        step();
        chk_b("n1_toggle", 4'b1010, 4'b1010, 4'b0101, 1'b1, 4'b1111);
        step();
        chk_b("n1_after", 4'b1010, 4'b0000, 4'b0000, 1'b0, 4'b1111);

        // Randomized traffic against the reference model, with one mid-run reset.
        din_a = '0; din_b = '0; clr_a = '0; clr_b = '0;
        reset_l = 1'b0;
        step();
        reset_l = 1'b1;
        model_reset(ma);
        model_reset(mb);
        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                reset_l = 1'b0;
                #2;
                chk_a("rand_rst", 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
                reset_l = 1'b1;
                model_reset(ma);
                model_reset(mb);
            end
            if ($urandom_range(0, 3) == 0) din_a = 4'($urandom);
            if ($urandom_range(0, 1) == 0) din_b = 4'($urandom);
            clr_a = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            clr_b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            step();
            model_step(ma, din_a, clr_a, N_A, ma, er, ef);
            model_step(mb, din_b, clr_b, N_B, mb, er_b, ef_b);
            chk_a($sformatf("rand%0d", c), ma.out, er, ef, |(er | ef), ma.sticky);
            chk_b($sformatf("rand%0d", c), mb.out, er_b, ef_b, |(er_b | ef_b), mb.sticky);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
